if_of_latch: RTL and testbench
==============================

Name: if_of_latch

Overview:
- Pipeline latch between the IF stage and the OF stage of the SimpleRISC core; it is the consumer end of the IF fetch interface.
- Captures each fetched instruction and its PC from IF into a 2-entry buffer (main slot plus skid slot), then presents them to OF under a valid/ready handshake.
- Back-pressures IF when full; discards wrong-path entries when a branch is taken.

Parameters:
- WIDTH, 32, width of PC and instruction words
- NOP_INST, 32'h68000000, SimpleRISC nop encoding; driven on out_inst whenever the latch is empty after reset/flush
- CNT_W, 16, width of the saturating performance counters

Ports:
- Clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high reset
- in_pc  in  WIDTH  PC of the fetched instruction (IF pc_current)
- in_inst  in  WIDTH  fetched instruction (IF Instruction)
- in_valid  in  1  IF presents a fetched instruction
- in_ready  out  1  latch can accept; IF holds its PC when low
- isBranchTaken  in  1  flush request from the branch unit
- out_pc  out  WIDTH  PC to OF
- out_inst  out  WIDTH  instruction to OF
- out_valid  out  1  out_pc/out_inst hold a valid entry
- out_ready  in  1  OF accepts this cycle
- flush_count  out  CNT_W  number of cycles with isBranchTaken=1 (saturating)
- stall_count  out  CNT_W  number of cycles with in_valid=1 and in_ready=0 (saturating)

Behaviour:
- Handshake definitions: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready. Data moves only on a fire; out_pc/out_inst are stable while out_valid=1 and out_ready=0.
- States: EMPTY (no entries), ONE (main slot valid), FULL (main and skid slots valid). Outputs are driven from the main slot.
- Registered outputs: out_valid = (state != EMPTY); in_ready = (state != FULL). No combinational path from any input to any output.
- Reset (synchronous, dominates everything): state=EMPTY, out_valid=0, in_ready=1, out_pc=0, out_inst=NOP_INST, skid slot cleared, both counters=0.
- Flush (isBranchTaken=1, no reset): next state=EMPTY, main slot becomes pc=0 / inst=NOP_INST, skid slot is dropped. Any in_fire in the same cycle is discarded as wrong-path. A coincident out_fire still completes for the entry already on the outputs.
- EMPTY: in_fire -> ONE, main<=in. Otherwise stay in EMPTY.
- ONE:
  - in_fire & out_fire -> ONE, main<=in (full throughput, no bubble)
  - in_fire & !out_fire -> FULL, skid<=in
  - !in_fire & out_fire -> EMPTY, main<=(0,NOP_INST)
  - neither -> hold
- FULL (in_ready=0): out_fire -> ONE, main<=skid. Otherwise hold.
- Latency: an entry accepted in cycle N is visible on the outputs in cycle N+1. Sustained throughput is 1 entry per cycle while out_ready=1.
- Ordering: strict FIFO. No entry is ever duplicated or lost, except those discarded by flush.
- Counters: increment by 1 per qualifying cycle and saturate at all-ones (no wrap). They are cleared only by reset; flush does not clear them.

Decomposition:
- Shared package simple_risc_pkg: WIDTH, NOP_INST, and the latch state encoding (EMPTY=2'd0, ONE=2'd1, FULL=2'd2).
- One natural sub-module, sat_counter (parameter CNT_W; inputs Clk, reset, inc; output count), instantiated twice.
- The state machine and both slots stay in if_of_latch.

Test Plan:
- Reset: hold reset=1 for 2 cycles -> out_valid=0, in_ready=1, out_inst=32'h68000000, out_pc=0, flush_count=0, stall_count=0.
- Streaming: out_ready=1; drive in_valid=1 with pc 0,4,8,C and inst A0..A3 -> the same sequence appears on the outputs one cycle later, with no bubbles and in_ready held at 1.
- Back-pressure: out_ready=0, push pc 0 and pc 4 -> after 2 cycles state=FULL and in_ready=0. Hold pc 8 for 3 cycles -> stall_count=3. Then set out_ready=1 -> outputs 0, 4, 8 in order with no loss.
- Flush while FULL: fill with pc 0x10 and 0x14, assert isBranchTaken with in_valid=1 and pc 0x18 -> next cycle out_valid=0, out_inst=NOP_INST, in_ready=1, flush_count=1. Then push pc 0x40 -> 0x40 is output next; 0x14 and 0x18 never appear.
- Simultaneous events: in state ONE, assert reset together with isBranchTaken and in_valid -> reset wins: EMPTY, flush_count stays 0. With isBranchTaken and out_ready=1 together -> the current entry completes and the latch is then EMPTY.
- Saturation: force CNT_W=4 and hold the flush high for 20 cycles -> flush_count stays at 4'hF.

Source files
------------

// File: rtl/simple_risc_pkg.sv
// Shared SimpleRISC definitions used by the IF/OF pipeline latch.
// Holds the datapath width, the nop encoding and the latch state encoding.
package simple_risc_pkg;

  localparam int WIDTH = 32;
  localparam logic [31:0] NOP_INST = 32'h6800_0000;

  typedef enum logic [1:0] {
    LATCH_EMPTY = 2'd0,
    LATCH_ONE   = 2'd1,
    LATCH_FULL  = 2'd2
  } latch_state_e;

endpackage

// File: rtl/if_of_latch_sat_counter.sv
// Saturating up-counter: counts qualifying cycles and sticks at all-ones.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);
  import simple_risc_pkg::*;

  logic [CNT_W-1:0] count_r;

  // Count register: cleared by reset, holds once every bit is set
  always_ff @(posedge Clk) begin
    if (reset) begin
      count_r <= {CNT_W{1'b0}};
    end else if (inc && (count_r != {CNT_W{1'b1}})) begin
      count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign count = count_r;

endmodule

// File: rtl/if_of_latch.sv
// IF -> OF pipeline latch: 2-entry (main + skid) buffer with valid/ready on
// both sides, wrong-path flush on taken branch, and flush/stall counters.
module if_of_latch #(
  parameter int          WIDTH    = simple_risc_pkg::WIDTH,
  parameter logic [31:0] NOP_INST = simple_risc_pkg::NOP_INST,
  parameter int          CNT_W    = 16
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_pc,
  input  logic [WIDTH-1:0] in_inst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             isBranchTaken,
  output logic [WIDTH-1:0] out_pc,
  output logic [WIDTH-1:0] out_inst,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] flush_count,
  output logic [CNT_W-1:0] stall_count
);
  import simple_risc_pkg::*;

  latch_state_e     state_r, state_s;
  logic [WIDTH-1:0] main_pc_r, main_inst_r, main_pc_s, main_inst_s;
  logic [WIDTH-1:0] skid_pc_r, skid_inst_r, skid_pc_s, skid_inst_s;
  logic             out_valid_r, in_ready_r;
  logic             in_fire_s, out_fire_s;

  assign in_fire_s  = in_valid & in_ready_r;
  assign out_fire_s = out_valid_r & out_ready;

  // Next-state and slot update; flush overrides every handshake outcome
  always_comb begin
    state_s     = state_r;
    main_pc_s   = main_pc_r;
    main_inst_s = main_inst_r;
    skid_pc_s   = skid_pc_r;
    skid_inst_s = skid_inst_r;
    if (isBranchTaken) begin
      state_s     = LATCH_EMPTY;
      main_pc_s   = {WIDTH{1'b0}};
      main_inst_s = NOP_INST[WIDTH-1:0];
      skid_pc_s   = {WIDTH{1'b0}};
      skid_inst_s = NOP_INST[WIDTH-1:0];
    end else begin
      case (state_r)
        LATCH_EMPTY: begin
          if (in_fire_s) begin
            state_s     = LATCH_ONE;
            main_pc_s   = in_pc;
            main_inst_s = in_inst;
          end else begin
            state_s = LATCH_EMPTY;
          end
        end
        LATCH_ONE: begin
          if (in_fire_s && out_fire_s) begin
            main_pc_s   = in_pc;
            main_inst_s = in_inst;
          end else if (in_fire_s) begin
            state_s     = LATCH_FULL;
            skid_pc_s   = in_pc;
            skid_inst_s = in_inst;
          end else if (out_fire_s) begin
            state_s     = LATCH_EMPTY;
            main_pc_s   = {WIDTH{1'b0}};
            main_inst_s = NOP_INST[WIDTH-1:0];
          end else begin
            state_s = LATCH_ONE;
          end
        end
        LATCH_FULL: begin
          // Skid entry is older than anything IF can offer, so it moves up
          if (out_fire_s) begin
            state_s     = LATCH_ONE;
            main_pc_s   = skid_pc_r;
            main_inst_s = skid_inst_r;
          end else begin
            state_s = LATCH_FULL;
          end
        end
        default: begin
          state_s     = LATCH_EMPTY;
          main_pc_s   = {WIDTH{1'b0}};
          main_inst_s = NOP_INST[WIDTH-1:0];
        end
      endcase
    end
  end

  // State, slots and handshake flags; flags derive from next state so they stay registered
  always_ff @(posedge Clk) begin
    if (reset) begin
      state_r     <= LATCH_EMPTY;
      main_pc_r   <= {WIDTH{1'b0}};
      main_inst_r <= NOP_INST[WIDTH-1:0];
      skid_pc_r   <= {WIDTH{1'b0}};
      skid_inst_r <= NOP_INST[WIDTH-1:0];
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
    end else begin
      state_r     <= state_s;
      main_pc_r   <= main_pc_s;
      main_inst_r <= main_inst_s;
      skid_pc_r   <= skid_pc_s;
      skid_inst_r <= skid_inst_s;
      out_valid_r <= (state_s != LATCH_EMPTY);
      in_ready_r  <= (state_s != LATCH_FULL);
    end
  end

  assign out_pc    = main_pc_r;
  assign out_inst  = main_inst_r;
  assign out_valid = out_valid_r;
  assign in_ready  = in_ready_r;

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .Clk   (Clk),
    .reset (reset),
    .inc   (isBranchTaken),
    .count (flush_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .Clk   (Clk),
    .reset (reset),
    .inc   (in_valid & ~in_ready_r),
    .count (stall_count)
  );

endmodule

// File: tb/tb_if_of_latch.sv
// Directed + randomized bench for if_of_latch against a queue-based FIFO model;
// a second instance with 4-bit counters exercises saturation.
module tb_if_of_latch;

  localparam logic [31:0] NOP = 32'h6800_0000;

  logic        Clk = 1'b0;
  logic        reset, in_valid, isBranchTaken, out_ready;
  logic [31:0] in_pc, in_inst;
  logic        in_ready, out_valid;
  logic [31:0] out_pc, out_inst;
  logic [15:0] flush_count, stall_count;
  logic        s_in_ready, s_out_valid;
  logic [31:0] s_out_pc, s_out_inst;
  logic [3:0]  s_flush_count, s_stall_count;

  typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;
  ent_t q[$];
  int   m_flush, m_stall;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 Clk = ~Clk;

  if_of_latch dut (
    .Clk(Clk), .reset(reset), .in_pc(in_pc), .in_inst(in_inst),
    .in_valid(in_valid), .in_ready(in_ready), .isBranchTaken(isBranchTaken),
    .out_pc(out_pc), .out_inst(out_inst), .out_valid(out_valid),
    .out_ready(out_ready), .flush_count(flush_count), .stall_count(stall_count)
  );

  if_of_latch #(.CNT_W(4)) dut_small (
    .Clk(Clk), .reset(reset), .in_pc(in_pc), .in_inst(in_inst),
    .in_valid(in_valid), .in_ready(s_in_ready), .isBranchTaken(isBranchTaken),
    .out_pc(s_out_pc), .out_inst(s_out_inst), .out_valid(s_out_valid),
    .out_ready(out_ready), .flush_count(s_flush_count), .stall_count(s_stall_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Model of one clock edge: FIFO of depth 2, flush empties it, reset dominates
  task automatic model_edge();
    bit rdy, vld;
    rdy = (q.size() < 2);
    vld = (q.size() > 0);
    if (reset) begin
      q.delete();
      m_flush = 0;
      m_stall = 0;
    end else begin
      if (isBranchTaken) m_flush++;
      if (in_valid && !rdy) m_stall++;
      if (vld && out_ready) void'(q.pop_front());
      if (isBranchTaken) q.delete();
      else if (in_valid && rdy) q.push_back('{pc: in_pc, inst: in_inst});
    end
  endtask

  function automatic int sat(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  task automatic compare_all();
    chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() > 0});
    chk("in_ready", {31'd0, in_ready}, {31'd0, q.size() < 2});
    chk("out_pc", out_pc, (q.size() > 0) ? q[0].pc : 32'd0);
    chk("out_inst", out_inst, (q.size() > 0) ? q[0].inst : NOP);
    chk("flush_count", {16'd0, flush_count}, sat(m_flush, 65535));
    chk("stall_count", {16'd0, stall_count}, sat(m_stall, 65535));
    chk("small_flush", {28'd0, s_flush_count}, sat(m_flush, 15));
    chk("small_stall", {28'd0, s_stall_count}, sat(m_stall, 15));
    chk("small_out_pc", s_out_pc, (q.size() > 0) ? q[0].pc : 32'd0);
  endtask

  task automatic step(input logic r, input logic iv, input logic br, input logic ordy,
                      input logic [31:0] pc, input logic [31:0] inst);
    reset = r; in_valid = iv; isBranchTaken = br; out_ready = ordy;
    in_pc = pc; in_inst = inst;
    @(posedge Clk);
    model_edge();
    #1;
    compare_all();
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; isBranchTaken = 1'b0; out_ready = 1'b0;
    in_pc = 32'd0; in_inst = 32'd0;
    q.delete(); m_flush = 0; m_stall = 0;

    // Reset for two cycles
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    chk("rst_inst", out_inst, 32'h6800_0000);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);

    // Streaming with no bubbles
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b1, 32'(4 * i), 32'hA0 + 32'(i));
      chk("stream_pc", out_pc, 32'(4 * i));
      chk("stream_ready", {31'd0, in_ready}, 32'd1);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0);

    // Back-pressure: fill, stall three cycles, then drain
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'hB0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h4, 32'hB1);
    chk("bp_full", {31'd0, in_ready}, 32'd0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 32'h8, 32'hB2);
    chk("bp_stall3", {16'd0, stall_count}, 32'd3);
    for (int i = 0; i < 4; i++) step(1'b0, q.size() < 2 || i == 0, 1'b0, 1'b1, 32'h8, 32'hB2);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);

    // Flush while full; wrong-path entry must be dropped
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h10, 32'hC0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h14, 32'hC1);
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'h18, 32'hC2);
    chk("fl_valid", {31'd0, out_valid}, 32'd0);
    chk("fl_inst", out_inst, 32'h6800_0000);
    chk("fl_cnt", {16'd0, flush_count}, 32'd1);
    step(1'b0, 1'b1, 1'b0, 1'b1, 32'h40, 32'hC3);
    chk("fl_next", out_pc, 32'h40);
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);

    // Reset beats coincident flush and push
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h44, 32'hD0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 32'h48, 32'hD1);
    chk("sim_rst_flush", {16'd0, flush_count}, 32'd0);
    // Flush with out_ready: current entry completes, latch ends empty
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h50, 32'hD2);
    step(1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 32'h0);
    chk("sim_flush_empty", {31'd0, out_valid}, 32'd0);

    // Saturation of the 4-bit counter
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
    chk("sat_small", {28'd0, s_flush_count}, 32'hF);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(99) == 0), ($urandom_range(3) != 0), ($urandom_range(19) == 0),
           ($urandom_range(2) != 0), {$urandom_range(1023), 2'b00}, $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
